// File: rtl/bsort100_main.sv
// bsort100_main: 100-element signed bubble-sort engine with a 2-channel slave RAM window.
// Define SLAVE_PORT_EN to enable external read/write of the array.
module bsort100_main #(
  parameter int MEM_var_26078_26084 = 64
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start_port,
  input  logic [1:0]   S_oe_ram,
  input  logic [1:0]   S_we_ram,
  input  logic [15:0]  S_addr_ram,
  input  logic [127:0] S_Wdata_ram,
  input  logic [13:0]  S_data_ram_size,
  output logic         done_port,
  output logic [127:0] Sout_Rdata_ram,
  output logic [1:0]   Sout_DataRdy
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_INIT  = 3'd1;
  localparam logic [2:0] S_PASS  = 3'd2;
  localparam logic [2:0] S_CHECK = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  logic [2:0] r_state;
  logic [6:0] r_i;
  logic [6:0] r_j;
  logic [6:0] r_pass;
  logic       r_swp;
  logic       r_done;

  logic signed [31:0] w_a [100];
  logic signed [31:0] w_lo;
  logic signed [31:0] w_hi;
  logic               w_swap;
  logic               w_init;
  logic [1:0]         w_we_ok;
  logic [1:0]         w_wr_ok;
  logic [1:0]         w_inr;
  logic [13:0]        w_idx;
  logic               w_unused;

  assign w_lo   = w_a[r_j];
  assign w_hi   = w_a[r_j + 7'd1];
  assign w_swap = (r_state == S_PASS) && (w_lo > w_hi);
  assign w_init = (r_state == S_INIT);

  for (genvar k = 0; k < 2; k++) begin : g_dec
    logic signed [31:0] w_off;
    assign w_off = 32'(S_addr_ram[8*k +: 8]) - MEM_var_26078_26084;
    assign w_inr[k] = (w_off >= 0) && (w_off < 100);
    assign w_idx[7*k +: 7] = w_off[6:0];
    assign w_we_ok[k] = S_we_ram[k] && w_inr[k]
                     && (S_data_ram_size[7*k +: 7] == 7'd32)
                     && (r_state == S_IDLE);
  end

`ifdef SLAVE_PORT_EN
  assign w_wr_ok  = w_we_ok;
  assign w_unused = ^{S_Wdata_ram[127:96], S_Wdata_ram[63:32]};
`else
  assign w_wr_ok  = 2'b00;
  assign w_unused = ^{S_oe_ram, S_Wdata_ram[127:96],
                      S_Wdata_ram[63:32], w_we_ok};
`endif

  // Channel 1 is checked first so it wins a same-word collision.
  for (genvar g = 0; g < 100; g++) begin : g_el
    logic signed [31:0] r_v;
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
        r_v <= '0;
      else if (w_init && r_i == 7'(g))
        r_v <= ~32'(g);
      else if (w_swap && r_j == 7'(g))
        r_v <= w_hi;
      else if (w_swap && (r_j + 7'd1) == 7'(g))
        r_v <= w_lo;
      else if (w_wr_ok[1] && w_idx[13:7] == 7'(g))
        r_v <= S_Wdata_ram[95:64];
      else if (w_wr_ok[0] && w_idx[6:0] == 7'(g))
        r_v <= S_Wdata_ram[31:0];
    end
    assign w_a[g] = r_v;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_i     <= '0;
      r_j     <= '0;
      r_pass  <= '0;
      r_swp   <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (start_port) begin
            r_state <= S_INIT;
            r_i     <= '0;
          end
        end
        S_INIT: begin
          if (r_i == 7'd99) begin
            r_state <= S_PASS;
            r_pass  <= '0;
            r_j     <= '0;
            r_swp   <= 1'b0;
          end else begin
            r_i <= r_i + 7'd1;
          end
        end
        S_PASS: begin
          if (w_swap)
            r_swp <= 1'b1;
          if (r_j == 7'd98 - r_pass)
            r_state <= S_CHECK;
          else
            r_j <= r_j + 7'd1;
        end
        S_CHECK: begin
          if (!r_swp || r_pass == 7'd98) begin
            r_state <= S_DONE;
          end else begin
            r_pass  <= r_pass + 7'd1;
            r_j     <= '0;
            r_swp   <= 1'b0;
            r_state <= S_PASS;
          end
        end
        S_DONE: begin
          r_done  <= 1'b1;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign done_port = r_done;

`ifdef SLAVE_PORT_EN
  logic [1:0]   r_rd_v1;
  logic [1:0]   r_rd_v2;
  logic [1:0]   r_wr_v1;
  logic [1:0]   r_rd_inr;
  logic [1:0]   r_rdy;
  logic [13:0]  r_rd_idx;
  logic [127:0] r_rd_d2;
  logic [127:0] r_rdata;

  // Reads: sample, fetch, present. Writes only acknowledge a cycle later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_v1  <= '0;
      r_rd_v2  <= '0;
      r_wr_v1  <= '0;
      r_rd_inr <= '0;
      r_rdy    <= '0;
      r_rd_idx <= '0;
      r_rd_d2  <= '0;
      r_rdata  <= '0;
    end else begin
      r_wr_v1  <= S_we_ram;
      r_rd_v1  <= S_oe_ram & ~S_we_ram;
      r_rd_idx <= w_idx;
      r_rd_inr <= w_inr;
      r_rd_v2  <= r_rd_v1;
      r_rdy    <= r_rd_v2 | r_wr_v1;
      for (int k = 0; k < 2; k++) begin
        if (r_rd_inr[k])
          r_rd_d2[64*k +: 64] <= {{32{w_a[r_rd_idx[7*k +: 7]][31]}},
                                  w_a[r_rd_idx[7*k +: 7]]};
        else
          r_rd_d2[64*k +: 64] <= '0;
        if (r_rd_v2[k])
          r_rdata[64*k +: 64] <= r_rd_d2[64*k +: 64];
      end
    end
  end

  assign Sout_Rdata_ram = r_rdata;
  assign Sout_DataRdy   = r_rdy;
`else
  assign Sout_Rdata_ram = '0;
  assign Sout_DataRdy   = '0;
`endif

endmodule

// File: tb/tb_bsort100_main.sv
// tb_bsort100_main: self-checking bench for bsort100_main.
// Expectations follow SLAVE_PORT_EN: slave outputs read as 0 when it is undefined.
module tb_bsort100_main;

`ifdef SLAVE_PORT_EN
  localparam bit EN = 1'b1;
`else
  localparam bit EN = 1'b0;
`endif
  localparam int BASE = 64;
  localparam int N    = 100;

  logic         clk;
  logic         rst_n;
  logic         start_port;
  logic [1:0]   S_oe_ram;
  logic [1:0]   S_we_ram;
  logic [15:0]  S_addr_ram;
  logic [127:0] S_Wdata_ram;
  logic [13:0]  S_data_ram_size;
  logic         done_port;
  logic [127:0] Sout_Rdata_ram;
  logic [1:0]   Sout_DataRdy;

  bsort100_main #(.MEM_var_26078_26084(BASE)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .start_port      (start_port),
    .S_oe_ram        (S_oe_ram),
    .S_we_ram        (S_we_ram),
    .S_addr_ram      (S_addr_ram),
    .S_Wdata_ram     (S_Wdata_ram),
    .S_data_ram_size (S_data_ram_size),
    .done_port       (done_port),
    .Sout_Rdata_ram  (Sout_Rdata_ram),
    .Sout_DataRdy    (Sout_DataRdy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  oe;
    logic [7:0]  a0;
    logic [7:0]  a1;
    logic [63:0] e0;
    logic [63:0] e1;
  } rvec_t;

  rvec_t tbl [9];
  int    ref_a [N];
  int    exp_lat;
  int    nvec = 0;
  int    nerr = 0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Reference: fixed descending load, early-exit bubble sort, count work.
  function automatic void model_sort();
    int c = 0;
    int p = 0;
    for (int i = 0; i < N; i++) ref_a[i] = -(i + 1);
    for (int ps = 0; ps < N - 1; ps++) begin
      bit sw = 0;
      p++;
      for (int j = 0; j < N - 1 - ps; j++) begin
        c++;
        if (ref_a[j] > ref_a[j+1]) begin
          int t = ref_a[j];
          ref_a[j] = ref_a[j+1];
          ref_a[j+1] = t;
          sw = 1;
        end
      end
      if (!sw) break;
    end
    exp_lat = N + c + p + 1;
  endfunction

  function automatic logic [63:0] exp_rd(input logic [7:0] a);
    int idx = int'(a) - BASE;
    if (!EN || idx < 0 || idx >= N) return 64'd0;
    return 64'(longint'(ref_a[idx]));
  endfunction

  task automatic rd(input string nm, input logic [1:0] oe,
                    input logic [7:0] a0, input logic [7:0] a1,
                    input logic [63:0] e0, input logic [63:0] e1);
    logic [1:0] r1, r2, r3;
    S_oe_ram = oe;
    S_addr_ram = {a1, a0};
    @(negedge clk);
    S_oe_ram = 2'b00;
    r1 = Sout_DataRdy;
    @(negedge clk);
    r2 = Sout_DataRdy;
    @(negedge clk);
    r3 = Sout_DataRdy;
    chk({nm, "_rdy"}, 64'({r1, r2, r3}), 64'({4'b0, EN ? oe : 2'b00}));
    if (oe[0]) chk({nm, "_d0"}, Sout_Rdata_ram[63:0], EN ? e0 : 64'd0);
    if (oe[1]) chk({nm, "_d1"}, Sout_Rdata_ram[127:64], EN ? e1 : 64'd0);
  endtask

  task automatic wr(input string nm, input logic [1:0] we,
                    input logic [1:0] oe,
                    input logic [7:0] a0, input logic [7:0] a1,
                    input logic [31:0] d0, input logic [31:0] d1,
                    input logic [6:0] z0, input logic [6:0] z1);
    logic [1:0] r1, r2, r3;
    S_we_ram = we;
    S_oe_ram = oe;
    S_addr_ram = {a1, a0};
    S_Wdata_ram = {32'($urandom), d1, 32'($urandom), d0};
    S_data_ram_size = {z1, z0};
    @(negedge clk);
    S_we_ram = 2'b00;
    S_oe_ram = 2'b00;
    r1 = Sout_DataRdy;
    @(negedge clk);
    r2 = Sout_DataRdy;
    @(negedge clk);
    r3 = Sout_DataRdy;
    chk({nm, "_rdy"}, 64'({r1, r2, r3}),
        64'({2'b00, EN ? we : 2'b00, 2'b00}));
  endtask

  task automatic model_wr(input logic [1:0] we, input logic [7:0] a0,
                          input logic [7:0] a1, input logic [31:0] d0,
                          input logic [31:0] d1, input logic [6:0] z0,
                          input logic [6:0] z1);
    int i0 = int'(a0) - BASE;
    int i1 = int'(a1) - BASE;
    if (!EN) return;
    if (we[0] && z0 == 7'd32 && i0 >= 0 && i0 < N) ref_a[i0] = int'(d0);
    if (we[1] && z1 == 7'd32 && i1 >= 0 && i1 < N) ref_a[i1] = int'(d1);
  endtask

  task automatic run_sort(input string nm, input bit busy_wr);
    int cnt = 0;
    int extra = 0;
    bit seen = 0;
    model_sort();
    start_port = 1'b1;
    @(negedge clk);
    start_port = 1'b0;
    while (!seen && cnt < 6000) begin
      if (busy_wr && cnt == 10) begin
        S_we_ram = 2'b01;
        S_addr_ram = {8'd0, 8'd64};
        S_Wdata_ram = 128'd5;
        S_data_ram_size = {7'd0, 7'd32};
      end
      if (cnt == 20) start_port = 1'b1;
      @(negedge clk);
      cnt++;
      start_port = 1'b0;
      if (busy_wr && cnt == 11) begin
        S_we_ram = 2'b00;
        chk({nm, "_busy_rdy0"}, 64'(Sout_DataRdy), 64'd0);
      end
      if (busy_wr && cnt == 12)
        chk({nm, "_busy_rdy1"}, 64'(Sout_DataRdy), EN ? 64'd1 : 64'd0);
      if (done_port) seen = 1;
    end
    chk({nm, "_latency"}, seen ? 64'(cnt) : 64'hFFFF, 64'(exp_lat));
    repeat (300) begin
      @(negedge clk);
      if (done_port) extra++;
    end
    chk({nm, "_done_once"}, 64'(extra), 64'd0);
  endtask

  initial begin
    int dcount;
    logic [1:0] rsum;
    rst_n = 1'b0;
    start_port = 1'b0;
    S_oe_ram = '0;
    S_we_ram = '0;
    S_addr_ram = '0;
    S_Wdata_ram = '0;
    S_data_ram_size = '0;
    for (int i = 0; i < N; i++) ref_a[i] = 0;

    tbl[0] = '{2'b01, 8'd64,  8'd0,   64'hFFFF_FFFF_FFFF_FF9C, 64'd0};
    tbl[1] = '{2'b10, 8'd0,   8'd163, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF};
    tbl[2] = '{2'b11, 8'd64,  8'd163, 64'hFFFF_FFFF_FFFF_FF9C,
               64'hFFFF_FFFF_FFFF_FFFF};
    tbl[3] = '{2'b01, 8'd100, 8'd0,   64'hFFFF_FFFF_FFFF_FFC0, 64'd0};
    tbl[4] = '{2'b10, 8'd0,   8'd113, 64'd0, 64'hFFFF_FFFF_FFFF_FFCD};
    tbl[5] = '{2'b11, 8'd63,  8'd164, 64'd0, 64'd0};
    tbl[6] = '{2'b11, 8'd200, 8'd0,   64'd0, 64'd0};
    tbl[7] = '{2'b01, 8'd255, 8'd0,   64'd0, 64'd0};
    tbl[8] = '{2'b10, 8'd0,   8'd65,  64'd0, 64'hFFFF_FFFF_FFFF_FF9D};

    repeat (2) @(negedge clk);
    chk("rst_done", 64'(done_port), 64'd0);
    chk("rst_rdy", 64'(Sout_DataRdy), 64'd0);
    chk("rst_rdata_lo", Sout_Rdata_ram[63:0], 64'd0);
    chk("rst_rdata_hi", Sout_Rdata_ram[127:64], 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_done", 64'(done_port), 64'd0);
    rd("rst_rd64", 2'b01, 8'd64, 8'd0, exp_rd(8'd64), 64'd0);

    run_sort("sort1", 1'b0);
    for (int k = 0; k < N; k++)
      rd($sformatf("scan%0d", k), 2'b01, 8'(BASE + k), 8'd0,
         exp_rd(8'(BASE + k)), 64'd0);
    for (int t = 0; t < 9; t++)
      rd($sformatf("tbl%0d", t), tbl[t].oe, tbl[t].a0, tbl[t].a1,
         tbl[t].e0, tbl[t].e1);

    run_sort("sort2", 1'b1);
    rd("busy_a0", 2'b01, 8'd64, 8'd0, exp_rd(8'd64), 64'd0);
    rd("busy_a200", 2'b01, 8'd200, 8'd0, 64'd0, 64'd0);

    for (int it = 0; it < 60; it++) begin
      logic [1:0]  we, oe, ro;
      logic [7:0]  a0, a1, b0, b1;
      logic [31:0] d0, d1;
      logic [6:0]  z0, z1;
      we = 2'($urandom_range(1, 3));
      oe = we & 2'($urandom);
      a0 = 8'($urandom_range(50, 180));
      a1 = ($urandom_range(0, 3) == 0) ? a0 : 8'($urandom_range(50, 180));
      d0 = $urandom;
      d1 = $urandom;
      z0 = ($urandom_range(0, 3) != 0) ? 7'd32 : 7'($urandom_range(0, 127));
      z1 = ($urandom_range(0, 3) != 0) ? 7'd32 : 7'($urandom_range(0, 127));
      wr($sformatf("rw%0d", it), we, oe, a0, a1, d0, d1, z0, z1);
      model_wr(we, a0, a1, d0, d1, z0, z1);
      ro = 2'($urandom_range(1, 3));
      b0 = ($urandom_range(0, 1) == 0) ? a0 : 8'($urandom_range(50, 180));
      b1 = ($urandom_range(0, 1) == 0) ? a1 : 8'($urandom_range(50, 180));
      rd($sformatf("rr%0d", it), ro, b0, b1, exp_rd(b0), exp_rd(b1));
    end

    // Abort a sort mid-run with a read still in flight.
    dcount = 0;
    start_port = 1'b1;
    @(negedge clk);
    start_port = 1'b0;
    for (int c = 1; c < 1998; c++) begin
      @(negedge clk);
      if (done_port) dcount++;
    end
    S_oe_ram = 2'b01;
    S_addr_ram = {8'd0, 8'd64};
    @(negedge clk);
    S_oe_ram = 2'b00;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_done", 64'(done_port), 64'd0);
    chk("abort_rdy", 64'(Sout_DataRdy), 64'd0);
    chk("abort_rdata", Sout_Rdata_ram[63:0], 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    rsum = 2'b00;
    repeat (3) begin
      @(negedge clk);
      rsum = rsum | Sout_DataRdy;
    end
    chk("abort_inflight", 64'(rsum), 64'd0);
    for (int i = 0; i < N; i++) ref_a[i] = 0;
    rd("abort_rd64", 2'b01, 8'd64, 8'd0, exp_rd(8'd64), 64'd0);
    repeat (5300) begin
      @(negedge clk);
      if (done_port) dcount++;
    end
    chk("abort_no_done", 64'(dcount), 64'd0);

    run_sort("sort3", 1'b0);
    rd("sort3_rd", 2'b11, 8'd64, 8'd163, exp_rd(8'd64), exp_rd(8'd163));

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
